// File: rtl/xpb_gen_pkg.sv
// Shared constants and state encoding for the runtime xpb table generator.
package xpb_gen_pkg;

    localparam int XPB_WIDTH    = 1024;
    localparam int XPB_IDX_BITS = 5;
    localparam int XPB_DEPTH    = 1 << XPB_IDX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        FIN
    } xpb_state_e;

endpackage

// File: rtl/xpb_mod_add.sv
// Combinational (a + b) mod n for operands already reduced below n.
module xpb_mod_add
    import xpb_gen_pkg::*;
#(
    parameter int WIDTH = XPB_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH:0] s;
    logic [WIDTH:0] diff;

    // The carry bit is kept so that a + b < 2n compares correctly against n.
    always_comb begin
        s    = {1'b0, a} + {1'b0, b};
        diff = s - {1'b0, n};
        sum  = (s >= {1'b0, n}) ? diff[WIDTH-1:0] : s[WIDTH-1:0];
    end

endmodule

// File: rtl/xpb_table_gen.sv
// Builds entry[i] = (i * B) mod N one entry per cycle and serves it through
// a latency-1 registered read port.
module xpb_table_gen
    import xpb_gen_pkg::*;
#(
    parameter int WIDTH    = XPB_WIDTH,
    parameter int IDX_BITS = XPB_IDX_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    mod_in,
    input  logic [WIDTH-1:0]    base_in,
    output logic                busy,
    output logic                done,
    output logic                ready,
    output logic                err,
    input  logic                rd_en,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [WIDTH-1:0]    data_out,
    output logic                rd_valid
);

    localparam int DEPTH = 1 << IDX_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DEPTH - 1);

    xpb_state_e state_q, state_d;
    logic [WIDTH-1:0]    n_q, n_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [IDX_BITS-1:0] cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                rd_valid_q, rd_valid_d;

    logic                wr_en;
    logic [IDX_BITS-1:0] wr_idx;
    logic [WIDTH-1:0]    wr_data;
    logic [WIDTH-1:0]    nxt;

    logic [WIDTH-1:0]    table_mem [DEPTH];

    xpb_mod_add #(.WIDTH(WIDTH)) u_mod_add (
        .a   (acc_q),
        .b   (b_q),
        .n   (n_q),
        .sum (nxt)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        b_d        = b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        err_d      = err_q;
        wr_en      = 1'b0;
        wr_idx     = cnt_q;
        wr_data    = nxt;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ready_d = 1'b0;
                    if (base_in < mod_in) begin
                        n_d     = mod_in;
                        b_d     = base_in;
                        acc_d   = '0;
                        cnt_d   = IDX_BITS'(1);
                        err_d   = 1'b0;
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        wr_data = '0;
                        state_d = GEN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GEN: begin
                wr_en = 1'b1;
                acc_d = nxt;
                // Ready rises with the last write so it is already high during FIN.
                if (cnt_q == LAST_IDX) begin
                    ready_d = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + IDX_BITS'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_valid_d = rd_en & ready_q;
        data_d     = rd_en ? table_mem[rd_idx] : data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            n_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            data_q     <= data_d;
        end
    end

    // Table contents survive reset; only the write in flight is suppressed.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            table_mem[wr_idx] <= wr_data;
        end
    end

    assign busy     = (state_q == GEN);
    assign done     = (state_q == FIN);
    assign ready    = ready_q;
    assign err      = err_q;
    assign data_out = data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Scoreboard bench for xpb_table_gen: a 16-bit instance for the directed cases
// and a 1024-bit instance checked against a wide (i*B) mod N model.
module tb_xpb_table_gen;

    localparam int W     = 16;
    localparam int IB    = 5;
    localparam int BW    = 1024;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start;
    logic [W-1:0]  mod_in, base_in;
    logic          busy, done, ready, err;
    logic          rd_en;
    logic [IB-1:0] rd_idx;
    logic [W-1:0]  data_out;
    logic          rd_valid;

    logic          start_big;
    logic [BW-1:0] mod_big, base_big;
    logic          busy_big, done_big, ready_big, err_big;
    logic          rd_en_big;
    logic [IB-1:0] rd_idx_big;
    logic [BW-1:0] data_big;
    logic          rd_valid_big;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [W-1:0]  exp_q[$];
    logic [BW-1:0] exp_big_q[$];
    logic [W-1:0]  mon_exp;
    logic [BW-1:0] mon_exp_big;

    xpb_table_gen #(.WIDTH(W), .IDX_BITS(IB)) dut (
        .clk(clk), .reset(reset), .start(start), .mod_in(mod_in), .base_in(base_in),
        .busy(busy), .done(done), .ready(ready), .err(err),
        .rd_en(rd_en), .rd_idx(rd_idx), .data_out(data_out), .rd_valid(rd_valid)
    );

    xpb_table_gen #(.WIDTH(BW), .IDX_BITS(IB)) dut_big (
        .clk(clk), .reset(reset), .start(start_big), .mod_in(mod_big), .base_in(base_big),
        .busy(busy_big), .done(done_big), .ready(ready_big), .err(err_big),
        .rd_en(rd_en_big), .rd_idx(rd_idx_big), .data_out(data_big), .rd_valid(rd_valid_big)
    );

    function automatic logic [W-1:0] model(input int i, input logic [W-1:0] n, input logic [W-1:0] b);
        logic [31:0] p;
        p = 32'(i) * {16'b0, b};
        p = p % {16'b0, n};
        return p[W-1:0];
    endfunction

    function automatic logic [BW-1:0] model_big(input int i, input logic [BW-1:0] n, input logic [BW-1:0] b);
        logic [BW+7:0] p;
        p = (BW+8)'(i) * {8'b0, b};
        p = p % {8'b0, n};
        return p[BW-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Monitors pop one expectation per rd_valid beat.
    always @(negedge clk) begin
        if (rd_valid) begin
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL rd_unexpected actual valid=1 data=%h required valid=0", data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (data_out !== mon_exp) begin
                    n_mismatched++;
                    $display("[TB] FAIL rd_data actual=%h required=%h", data_out, mon_exp);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rd_valid_big) begin
            n_compared++;
            if (exp_big_q.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL big_unexpected actual valid=1 required valid=0");
            end else begin
                mon_exp_big = exp_big_q.pop_front();
                if (data_big !== mon_exp_big) begin
                    n_mismatched++;
                    $display("[TB] FAIL big_data actual_lo=%h required_lo=%h", data_big[127:0], mon_exp_big[127:0]);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] n, input logic [W-1:0] b);
        @(negedge clk);
        start   = 1'b1;
        mod_in  = n;
        base_in = b;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic waitDone(output int lat, output int busy_cycles);
        lat         = 1;
        busy_cycles = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic readIdx(input int idx, input bit push, input logic [W-1:0] expv);
        rd_en  = 1'b1;
        rd_idx = IB'(idx);
        if (push) exp_q.push_back(expv);
        @(negedge clk);
        rd_en  = 1'b0;
    endtask

    task automatic readAll(input logic [W-1:0] n, input logic [W-1:0] b);
        for (int i = 0; i < DEPTH; i++) readIdx(i, 1'b1, model(i, n, b));
    endtask

    task automatic drainCheck(input string name);
        repeat (2) @(negedge clk);
        checkOutput(name, exp_q.size(), 0);
    endtask

    task automatic runBig(input logic [BW-1:0] b, input string name);
        int lat;
        @(negedge clk);
        start_big = 1'b1;
        base_big  = b;
        @(negedge clk);
        start_big = 1'b0;
        lat = 1;
        while (!done_big && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({name, "_done_latency"}, lat, 32);
        for (int i = 0; i < DEPTH; i++) begin
            rd_en_big  = 1'b1;
            rd_idx_big = IB'(i);
            exp_big_q.push_back(model_big(i, mod_big, b));
            @(negedge clk);
        end
        rd_en_big = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput({name, "_drain"}, exp_big_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int bc;
        logic [BW-1:0]  pow825;
        logic [BW+7:0]  pow1030;

        reset = 1'b1; start = 1'b0; mod_in = '0; base_in = '0; rd_en = 1'b0; rd_idx = '0;
        start_big = 1'b0; mod_big = '0; base_big = '0; rd_en_big = 1'b0; rd_idx_big = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ready", ready, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_data_out", data_out, 0);
        checkOutput("rst_big_data", data_big[31:0], 0);
        reset = 1'b0;

        $display("[TB] basic generation N=FFF1 B=9F8D");
        applyStimulus(16'hFFF1, 16'h9F8D);
        checkOutput("gen_ready_low", ready, 0);
        waitDone(lat, bc);
        checkOutput("done_latency", lat, 32);
        checkOutput("busy_cycles", bc, 31);
        checkOutput("ready_at_done", ready, 1);
        @(negedge clk);
        checkOutput("done_one_cycle", done, 0);
        checkOutput("ready_held", ready, 1);
        readIdx(0, 1'b1, 16'h0000);
        readIdx(1, 1'b1, 16'h9F8D);
        readIdx(2, 1'b1, 16'h3F29);
        readIdx(3, 1'b1, 16'hDEB6);
        drainCheck("hand_drain");
        readAll(16'hFFF1, 16'h9F8D);
        drainCheck("all_drain");

        $display("[TB] rejected start B >= N");
        applyStimulus(16'hFFF1, 16'hFFF1);
        checkOutput("rej_err", err, 1);
        checkOutput("rej_busy", busy, 0);
        checkOutput("rej_ready", ready, 0);
        applyStimulus(16'h0000, 16'h0000);
        checkOutput("rej_zero_err", err, 1);
        checkOutput("rej_zero_busy", busy, 0);
        readIdx(1, 1'b0, 16'h0000);
        applyStimulus(16'hFFF1, 16'h9F8D);
        checkOutput("accept_clears_err", err, 0);
        checkOutput("accept_busy", busy, 1);
        waitDone(lat, bc);
        checkOutput("accept_done_seen", done, 1);

        $display("[TB] reset during generation");
        applyStimulus(16'hFFF1, 16'h1234);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_ready", ready, 0);
        reset = 1'b0;
        applyStimulus(16'hFFF1, 16'h0001);
        waitDone(lat, bc);
        checkOutput("restart_latency", lat, 32);
        @(negedge clk);
        readIdx(31, 1'b1, 16'h001F);
        readIdx(5, 1'b1, 16'h0005);
        drainCheck("restart_drain");

        $display("[TB] start ignored while generating");
        applyStimulus(16'hFFF1, 16'h9F8D);
        repeat (4) @(negedge clk);
        start = 1'b1; mod_in = 16'hFFFB; base_in = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        readIdx(3, 1'b0, 16'h0000);
        waitDone(lat, bc);
        checkOutput("ignore_done_seen", done, 1);
        checkOutput("ignore_err", err, 0);
        @(negedge clk);
        readAll(16'hFFF1, 16'h9F8D);
        drainCheck("ignore_drain");

        $display("[TB] 1024-bit tables");
        mod_big = {32{32'hC3A5_96E1}};
        pow825 = '0;
        pow825[825] = 1'b1;
        runBig(pow825 % mod_big, "big825");
        // 2^1030 mod N exercises the conditional subtract at full width.
        pow1030 = '0;
        pow1030[1030] = 1'b1;
        pow1030 = pow1030 % {8'b0, mod_big};
        runBig(pow1030[BW-1:0], "big1030");
        checkOutput("big_err", err_big, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
